// File: rtl/pipelined_addsub.sv
// pipelined_addsub
//
// Pipelined add/subtract on WIDTH-bit operands. The carry chain is split into
// STAGES segments of SEG = WIDTH/STAGES bits, one segment resolved per stage.
// Every beat chooses add or subtract, signed or unsigned overflow rules, and
// wrap or saturate. Overflow is always reported. A sideband tag rides along
// untouched. STAGES must lie in 1..WIDTH and divide WIDTH exactly.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   block can accept a beat this cycle (combinational from out_ready)
//   in_a       operand A
//   in_b       operand B
//   in_sub     1: A-B, 0: A+B
//   in_signed  1: two's-complement overflow rules, 0: unsigned
//   in_sat     1: saturate on overflow, 0: wrap
//   in_tag     sideband returned with the result
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_sum    result
//   out_ovf    overflow/borrow occurred
//   out_tag    tag of this result
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_signed,
  input  logic             in_sat,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Everything a stage carries. Operand B is stored already inverted for
  // subtraction, so every stage simply adds b with the incoming carry.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             sub;
    logic             sgn;
    logic             sat;
    logic             ovf;
    logic [TAG_W-1:0] tag;
  } stage_t;

  stage_t            st_q [STAGES];
  stage_t            st_d [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic [STAGES-1:0] load;

  // Load enables, walked from the output back towards the input. A stage
  // loads when it is empty or when the stage after it loads, so empty stages
  // fill behind a stalled one and bubbles collapse.
  always_comb begin
    logic chain;
    load       = '0;
    chain      = !vld_q[LAST] || out_ready;
    load[LAST] = chain;
    for (int k = STAGES - 2; k >= 0; k--) begin
      chain   = !vld_q[k] || chain;
      load[k] = chain;
    end
  end

  assign in_ready = load[0];

  // Next contents of each stage. Stage k takes its predecessor's state (or
  // the raw input for stage 0) and resolves segment k of the carry chain.
  // The last stage also works out overflow and applies saturation, so the
  // output register already holds the final answer.
  always_comb begin
    stage_t           src;
    logic [SEG:0]     seg_res;
    logic             sign_a;
    logic             sign_b;
    logic             sign_r;
    logic             ovf;
    logic [WIDTH-1:0] sat_val;
    int               p;
    src     = '0;
    seg_res = '0;
    sign_a  = 1'b0;
    sign_b  = 1'b0;
    sign_r  = 1'b0;
    ovf     = 1'b0;
    sat_val = '0;
    p       = 0;
    for (int k = 0; k < STAGES; k++) begin
      p = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        src.a     = in_a;
        src.b     = in_sub ? ~in_b : in_b;
        src.sum   = '0;
        src.carry = in_sub;
        src.sub   = in_sub;
        src.sgn   = in_signed;
        src.sat   = in_sat;
        src.ovf   = 1'b0;
        src.tag   = in_tag;
        vld_d[k]  = in_valid;
      end else begin
        src      = st_q[p];
        vld_d[k] = vld_q[p];
      end

      seg_res = {1'b0, src.a[k*SEG +: SEG]} + {1'b0, src.b[k*SEG +: SEG]}
              + {{SEG{1'b0}}, src.carry};

      st_d[k]                  = src;
      st_d[k].sum[k*SEG +: SEG] = seg_res[SEG-1:0];
      st_d[k].carry            = seg_res[SEG];
      st_d[k].ovf              = 1'b0;

      if (k == LAST) begin
        // Signs are taken from A and the (possibly inverted) B actually added.
        sign_a = src.a[WIDTH-1];
        sign_b = src.b[WIDTH-1];
        sign_r = st_d[k].sum[WIDTH-1];
        if (src.sgn) begin
          ovf     = (sign_a == sign_b) && (sign_r != sign_a);
          sat_val = sign_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
          // For subtraction a missing carry-out means a borrow.
          ovf     = src.sub ? !seg_res[SEG] : seg_res[SEG];
          sat_val = src.sub ? '0 : '1;
        end
        st_d[k].ovf = ovf;
        if (src.sat && ovf) begin
          st_d[k].sum = sat_val;
        end
      end
    end
  end

  // Stage registers. Data is only captured alongside a valid beat so the
  // output holds its last result rather than flickering with bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          vld_q[k] <= vld_d[k];
          if (vld_d[k]) begin
            st_q[k] <= st_d[k];
          end
        end
      end
    end
  end

  assign out_valid = vld_q[LAST];
  assign out_sum   = st_q[LAST].sum;
  assign out_ovf   = st_q[LAST].ovf;
  assign out_tag   = st_q[LAST].tag;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub
//
// Drives pipelined_addsub (STAGES=2) plus STAGES=1 and STAGES=4 copies that
// share the same inputs. Results are compared with a plain-arithmetic model
// and with hand-computed constants.
module tb_pipelined_addsub;

  localparam int W  = 32;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_sub = 1'b0;
  logic          in_signed = 1'b0;
  logic          in_sat = 1'b0;
  logic [TW-1:0] in_tag = '0;
  logic          out_ready = 1'b0;

  logic          in_ready, out_valid, out_ovf;
  logic [W-1:0]  out_sum;
  logic [TW-1:0] out_tag;
  logic          rdy1, val1, ovf1;
  logic [W-1:0]  sum1;
  logic [TW-1:0] tag1;
  logic          rdy4, val4, ovf4;
  logic [W-1:0]  sum4;
  logic [TW-1:0] tag4;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(W), .STAGES(2), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_signed(in_signed),
    .in_sat(in_sat), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf),
    .out_tag(out_tag));

  pipelined_addsub #(.WIDTH(W), .STAGES(1), .TAG_W(TW)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_signed(in_signed),
    .in_sat(in_sat), .in_tag(in_tag), .out_valid(val1),
    .out_ready(out_ready), .out_sum(sum1), .out_ovf(ovf1),
    .out_tag(tag1));

  pipelined_addsub #(.WIDTH(W), .STAGES(4), .TAG_W(TW)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_signed(in_signed),
    .in_sat(in_sat), .in_tag(in_tag), .out_valid(val4),
    .out_ready(out_ready), .out_sum(sum4), .out_ovf(ovf4),
    .out_tag(tag4));

  typedef struct packed {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sub;
    logic          sgn;
    logic          sat;
    logic [TW-1:0] tag;
  } beat_t;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic          ovf;
    logic [W-1:0]  sum;
  } res_t;

  beat_t beats_q [$];
  res_t  exp_q [$];
  res_t  obs_q [$];
  beat_t cur;
  bit    have_beat = 1'b0;
  bit    last_acc = 1'b0;
  bit    last_in_ready = 1'b0;
  int    n_checks = 0;
  int    n_fail = 0;

  // Reference: exact integer arithmetic, then range tests for overflow.
  function automatic res_t model(input beat_t bt);
    longint ra, rb, r;
    longint smax, smin, umax;
    res_t   res;
    smax = 64'sd2147483647;
    smin = -smax - 64'sd1;
    umax = 64'sd4294967295;
    if (bt.sgn) begin
      ra = longint'($signed(bt.a));
      rb = longint'($signed(bt.b));
    end else begin
      ra = longint'({32'd0, bt.a});
      rb = longint'({32'd0, bt.b});
    end
    r = bt.sub ? ra - rb : ra + rb;
    res.tag = bt.tag;
    res.sum = r[31:0];
    if (bt.sgn) res.ovf = (r > smax) || (r < smin);
    else        res.ovf = (r > umax) || (r < 64'sd0);
    if (bt.sat && res.ovf) begin
      if (bt.sgn) res.sum = (r > 64'sd0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      else        res.sum = (r > 64'sd0) ? 32'hFFFF_FFFF : 32'h0000_0000;
    end
    return res;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  function automatic beat_t rand_beat(input logic [TW-1:0] tag);
    beat_t bt;
    bt.a   = pick_operand();
    bt.b   = pick_operand();
    bt.sub = 1'($urandom_range(1));
    bt.sgn = 1'($urandom_range(1));
    bt.sat = 1'($urandom_range(1));
    bt.tag = tag;
    return bt;
  endfunction

  function automatic beat_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic sub, input logic sgn, input logic sat,
                               input logic [TW-1:0] tag);
    beat_t bt;
    bt.a = a; bt.b = b; bt.sub = sub; bt.sgn = sgn; bt.sat = sat; bt.tag = tag;
    return bt;
  endfunction

  // One clock: present the pending beat and out_ready at the falling edge,
  // then record what the coming rising edge will accept and consume.
  task automatic cycle(input bit rdy, input bit gaps);
    @(negedge clk);
    if (!have_beat && beats_q.size() != 0 && (!gaps || $urandom_range(3) != 0)) begin
      cur = beats_q.pop_front();
      have_beat = 1'b1;
    end
    out_ready = rdy;
    in_valid  = have_beat;
    in_a      = cur.a;
    in_b      = cur.b;
    in_sub    = cur.sub;
    in_signed = cur.sgn;
    in_sat    = cur.sat;
    in_tag    = cur.tag;
    #1;
    last_in_ready = in_ready;
    last_acc = in_valid && in_ready;
    if (out_valid && out_ready) obs_q.push_back('{tag: out_tag, ovf: out_ovf, sum: out_sum});
    if (last_acc) begin
      exp_q.push_back(model(cur));
      have_beat = 1'b0;
    end
  endtask

  task automatic drain(input bit rand_rdy, input bit gaps, input int budget, output bit timeout);
    int n;
    n = 0;
    while ((beats_q.size() != 0 || have_beat || obs_q.size() < exp_q.size()) && n < budget) begin
      cycle(rand_rdy ? ($urandom_range(3) != 0) : 1'b1, gaps);
      n++;
    end
    timeout = (n >= budget);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    have_beat = 1'b0;
    beats_q.delete();
    exp_q.delete();
    obs_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_sum !== '0) begin n_fail++; $display("[TB] FAIL reset_sum: got %h expected 0", out_sum); end
    n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ovf: got %b expected 0", out_ovf); end
    n_checks++; if (out_tag !== '0) begin n_fail++; $display("[TB] FAIL reset_tag: got %h expected 0", out_tag); end
    do_reset();
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'd5; in_b = 32'd0; in_sub = 1'b0;
    in_signed = 1'b0; in_sat = 1'b0; in_tag = 4'hA; out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_accept: got %b expected 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_early_valid: got %b expected 0", out_valid); end
    @(negedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_sum !== 32'd5) begin n_fail++; $display("[TB] FAIL basic_sum: got %h expected 5", out_sum); end
    n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_ovf: got %b expected 0", out_ovf); end
    n_checks++; if (out_tag !== 4'hA) begin n_fail++; $display("[TB] FAIL basic_tag: got %h expected a", out_tag); end
    @(negedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_consumed: got %b expected 0", out_valid); end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [9];
    logic [W-1:0] vb [9];
    logic [W-1:0] es [9];
    logic [2:0]   md [9];
    logic         eo [9];
    bit           to;
    // md = {sub, signed, sat}
    va = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'h7FFF_FFFF, 32'h8000_0000,
           32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'd3};
    vb = '{32'd1, 32'd1, 32'd5, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd5};
    md = '{3'b000, 3'b001, 3'b101, 3'b011, 3'b111, 3'b110, 3'b010, 3'b000, 3'b100};
    es = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h7FFF_FFFF, 32'h8000_0000,
           32'h7FFF_FFFF, 32'h0, 32'h0001_0000, 32'hFFFF_FFFE};
    eo = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 9; i++)
      beats_q.push_back(mk(va[i], vb[i], md[i][2], md[i][1], md[i][0], 4'(i)));
    drain(1'b0, 1'b0, 200, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("[TB] FAIL directed_timeout: got %b expected 0", to); end
    n_checks++; if (obs_q.size() != 9) begin n_fail++; $display("[TB] FAIL directed_count: got %0d expected 9", obs_q.size()); end
    for (int i = 0; i < 9 && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].sum !== es[i] || obs_q[i].ovf !== eo[i] || obs_q[i].tag !== 4'(i)) begin
        n_fail++;
        $display("[TB] FAIL directed_%0d: got sum=%h ovf=%b tag=%h expected sum=%h ovf=%b tag=%h",
                 i, obs_q[i].sum, obs_q[i].ovf, obs_q[i].tag, es[i], eo[i], 4'(i));
      end
    end
  endtask

  task automatic test_stages();
    int c1, c2, c4;
    logic [W-1:0] s1, s2, s4;
    logic o1, o2, o4;
    c1 = -1; c2 = -1; c4 = -1;
    s1 = 'x; s2 = 'x; s4 = 'x; o1 = 1'bx; o2 = 1'bx; o4 = 1'bx;
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'h0000_FFFF; in_b = 32'd1; in_sub = 1'b0;
    in_signed = 1'b0; in_sat = 1'b0; in_tag = 4'h3; out_ready = 1'b1;
    #1;
    n_checks++; if ({rdy1, in_ready, rdy4} !== 3'b111) begin n_fail++; $display("[TB] FAIL stages_accept: got %b expected 111", {rdy1, in_ready, rdy4}); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (val1 && c1 < 0) begin c1 = c; s1 = sum1; o1 = ovf1; end
      if (out_valid && c2 < 0) begin c2 = c; s2 = out_sum; o2 = out_ovf; end
      if (val4 && c4 < 0) begin c4 = c; s4 = sum4; o4 = ovf4; end
    end
    n_checks++; if (c1 != 0) begin n_fail++; $display("[TB] FAIL stages1_latency: got %0d expected 0", c1); end
    n_checks++; if (c2 != 1) begin n_fail++; $display("[TB] FAIL stages2_latency: got %0d expected 1", c2); end
    n_checks++; if (c4 != 3) begin n_fail++; $display("[TB] FAIL stages4_latency: got %0d expected 3", c4); end
    n_checks++; if (s1 !== 32'h0001_0000 || o1 !== 1'b0) begin n_fail++; $display("[TB] FAIL stages1_sum: got %h/%b expected 00010000/0", s1, o1); end
    n_checks++; if (s2 !== 32'h0001_0000 || o2 !== 1'b0) begin n_fail++; $display("[TB] FAIL stages2_sum: got %h/%b expected 00010000/0", s2, o2); end
    n_checks++; if (s4 !== 32'h0001_0000 || o4 !== 1'b0) begin n_fail++; $display("[TB] FAIL stages4_sum: got %h/%b expected 00010000/0", s4, o4); end
  endtask

  task automatic test_backpressure();
    int   acc_stall, stable_err, cyc;
    bit   ir5, held_prev;
    res_t held;
    acc_stall = 0; stable_err = 0; cyc = 0; ir5 = 1'b1; held_prev = 1'b0; held = '0;
    do_reset();
    for (int i = 0; i < 8; i++) beats_q.push_back(mk(32'(i), 32'd100, 1'b0, 1'b0, 1'b0, 4'(i)));
    while ((beats_q.size() != 0 || have_beat || obs_q.size() < 8) && cyc < 60) begin
      cycle(cyc >= 6, 1'b0);
      if (held_prev && (out_valid !== 1'b1 || out_sum !== held.sum || out_ovf !== held.ovf || out_tag !== held.tag))
        stable_err++;
      held_prev = out_valid && !out_ready;
      held = '{tag: out_tag, ovf: out_ovf, sum: out_sum};
      if (cyc < 6 && last_acc) acc_stall++;
      if (cyc == 5) ir5 = last_in_ready;
      cyc++;
    end
    n_checks++; if (cyc >= 60) begin n_fail++; $display("[TB] FAIL bp_timeout: got %0d cycles expected < 60", cyc); end
    n_checks++; if (acc_stall != 2) begin n_fail++; $display("[TB] FAIL bp_held_beats: got %0d expected 2", acc_stall); end
    n_checks++; if (ir5 !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_in_ready: got %b expected 0", ir5); end
    n_checks++; if (stable_err != 0) begin n_fail++; $display("[TB] FAIL bp_stable: got %0d changes expected 0", stable_err); end
    n_checks++; if (obs_q.size() != 8) begin n_fail++; $display("[TB] FAIL bp_count: got %0d expected 8", obs_q.size()); end
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].sum !== 32'(100 + i) || obs_q[i].tag !== 4'(i) || obs_q[i].ovf !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL bp_result_%0d: got sum=%0d tag=%h ovf=%b expected sum=%0d tag=%h ovf=0",
                 i, obs_q[i].sum, obs_q[i].tag, obs_q[i].ovf, 100 + i, 4'(i));
      end
    end
  endtask

  task automatic test_back_to_back();
    int accepts;
    bit to;
    accepts = 0;
    do_reset();
    for (int i = 0; i < 16; i++) beats_q.push_back(rand_beat(4'(i)));
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0);
      if (last_acc) accepts++;
    end
    drain(1'b0, 1'b0, 50, to);
    n_checks++; if (accepts != 16) begin n_fail++; $display("[TB] FAIL b2b_throughput: got %0d expected 16", accepts); end
    n_checks++; if (to !== 1'b0 || obs_q.size() != 16) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d expected 16", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("[TB] FAIL b2b_%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    bit to;
    do_reset();
    for (int i = 0; i < 300; i++) beats_q.push_back(rand_beat(4'($urandom_range(15))));
    drain(1'b1, 1'b1, 5000, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("[TB] FAIL random_timeout: got %b expected 0", to); end
    n_checks++; if (obs_q.size() != 300) begin n_fail++; $display("[TB] FAIL random_count: got %0d expected 300", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("[TB] FAIL random_%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int spurious, ir_low;
    bit to;
    spurious = 0; ir_low = 0;
    do_reset();
    beats_q.push_back(mk(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b0, 4'h5));
    beats_q.push_back(mk(32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 4'h6));
    repeat (4) cycle(1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b1 || out_tag !== 4'h5) begin n_fail++; $display("[TB] FAIL mid_inflight: got %b/%h expected 1/5", out_valid, out_tag); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_ovf !== 1'b0 || out_tag !== '0) begin
      n_fail++;
      $display("[TB] FAIL mid_async_clear: got valid=%b sum=%h ovf=%b tag=%h expected all 0",
               out_valid, out_sum, out_ovf, out_tag);
    end
    have_beat = 1'b0; in_valid = 1'b0;
    beats_q.delete(); exp_q.delete(); obs_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0);
      if (out_valid) spurious++;
      if (!last_in_ready) ir_low++;
    end
    n_checks++; if (spurious != 0) begin n_fail++; $display("[TB] FAIL mid_stale: got %0d valid cycles expected 0", spurious); end
    n_checks++; if (ir_low != 0) begin n_fail++; $display("[TB] FAIL mid_in_ready: got %0d low cycles expected 0", ir_low); end
    beats_q.push_back(mk(32'd7, 32'd8, 1'b0, 1'b0, 1'b0, 4'h3));
    drain(1'b0, 1'b0, 20, to);
    n_checks++; if (to !== 1'b0 || obs_q.size() != 1) begin n_fail++; $display("[TB] FAIL mid_count: got %0d expected 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      n_checks++;
      if (obs_q[0].sum !== 32'd15 || obs_q[0].tag !== 4'h3) begin
        n_fail++;
        $display("[TB] FAIL mid_new_beat: got sum=%0d tag=%h expected sum=15 tag=3", obs_q[0].sum, obs_q[0].tag);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_stages();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
